pci_mem_target: RTL and testbench

Memory-space target sequencer for BAR0, directly downstream of `pci_busif`. It consumes decoded address and data phases, claims hits against the BAR0 window and services linear bursts into an on-block byte-lane-writable RAM. It inserts read wait states and issues target disconnects at the burst limit. `pci_busif` converts `claim`, `dp_ack` and `dp_stop` into DEVSEL#, TRDY# and STOP# pin timing.

---
 rtl/pci_pkg.sv | 49 ++++
 rtl/pci_mem_target_if.sv | 31 +++
 rtl/pci_mem_ram.sv | 38 +++
 rtl/pci_mem_target.sv | 166 ++++++++++++++++
 tb/tb_pci_mem_target.sv | 302 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/pci_pkg.sv
`default_nettype none
// ============================================================================
// Module   : pci_pkg
// Purpose  : Shared PCI command encodings, memory-target state type and
//            command classification helpers.
// Revision : 1.0
// ============================================================================
package pci_pkg;

  typedef enum logic [3:0] {
    CMD_INT_ACK       = 4'b0000,
    CMD_SPECIAL_CYCLE = 4'b0001,
    CMD_IO_READ       = 4'b0010,
    CMD_IO_WRITE      = 4'b0011,
    CMD_RSVD_4        = 4'b0100,
    CMD_RSVD_5        = 4'b0101,
    CMD_MEM_READ      = 4'b0110,
    CMD_MEM_WRITE     = 4'b0111,
    CMD_RSVD_8        = 4'b1000,
    CMD_RSVD_9        = 4'b1001,
    CMD_CFG_READ      = 4'b1010,
    CMD_CFG_WRITE     = 4'b1011,
    CMD_MEM_READ_MULT = 4'b1100,
    CMD_DUAL_ADDR     = 4'b1101,
    CMD_MEM_READ_LINE = 4'b1110,
    CMD_MEM_WRITE_INV = 4'b1111
  } pci_cmd_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CLAIM = 2'd1,
    ST_DATA  = 2'd2,
    ST_DISC  = 2'd3
  } pci_mem_state_t;

  function automatic logic is_mem_cmd(input logic [3:0] cmd);
    case (pci_cmd_t'(cmd))
      CMD_MEM_READ, CMD_MEM_WRITE, CMD_MEM_READ_MULT,
      CMD_MEM_READ_LINE, CMD_MEM_WRITE_INV: return 1'b1;
      default:                              return 1'b0;
    endcase
  endfunction

  function automatic logic is_mem_write(input logic [3:0] cmd);
    return (cmd == CMD_MEM_WRITE) || (cmd == CMD_MEM_WRITE_INV);
  endfunction

endpackage
`default_nettype wire

// File: rtl/pci_mem_target_if.sv
`default_nettype none
// ============================================================================
// Module   : pci_mem_target_if
// Purpose  : Decoded address/data-phase bundle between pci_busif (master)
//            and the BAR0 memory target (slave).
// Revision : 1.0
// ============================================================================
interface pci_mem_target_if;
  logic        addr_valid;
  logic [31:0] addr;
  logic [3:0]  cmd;
  logic        dp_req;
  logic [31:0] dp_wdata;
  logic [3:0]  dp_be;
  logic        txn_end;
  logic        claim;
  logic        dp_ack;
  logic        dp_stop;
  logic [31:0] dp_rdata;

  modport master (
    output addr_valid, addr, cmd, dp_req, dp_wdata, dp_be, txn_end,
    input  claim, dp_ack, dp_stop, dp_rdata
  );

  modport slave (
    input  addr_valid, addr, cmd, dp_req, dp_wdata, dp_be, txn_end,
    output claim, dp_ack, dp_stop, dp_rdata
  );
endinterface
`default_nettype wire

// File: rtl/pci_mem_ram.sv
`default_nettype none
// ============================================================================
// Module   : pci_mem_ram
// Purpose  : Single-port synchronous RAM, 32-bit words, per-byte write
//            enables, 1-cycle registered read (output register resets to 0).
// Revision : 1.0
// ============================================================================
module pci_mem_ram #(
  parameter int WORD_BITS = 8
) (
  input  wire logic                 clk,
  input  wire logic                 rst,
  input  wire logic                 re,
  input  wire logic [3:0]           we,
  input  wire logic [WORD_BITS-1:0] addr,
  input  wire logic [31:0]          wdata,
  output wire logic [31:0]          rdata
);
  localparam int DEPTH = 1 << WORD_BITS;

  // One narrow array per byte lane keeps each lane single-driven.
  for (genvar i = 0; i < 4; i++) begin : g_lane
    logic [7:0] r_mem [DEPTH];
    logic [7:0] r_rd;

    always_ff @(posedge clk) begin
      if (we[i]) r_mem[addr] <= wdata[8*i +: 8];
    end

    always_ff @(posedge clk or negedge rst) begin
      if (!rst)    r_rd <= '0;
      else if (re) r_rd <= r_mem[addr];
    end

    assign rdata[8*i +: 8] = r_rd;
  end
endmodule
`default_nettype wire

// File: rtl/pci_mem_target.sv
`default_nettype none
// ============================================================================
// Module   : pci_mem_target
// Purpose  : BAR0 memory-space target: claims hits, services linear bursts
//            into local RAM, disconnects at BURST_MAX or non-linear order.
// Config   : PCI_MEM_PREFETCH_EN -> zero-wait-state reads via prefetch.
// Revision : 1.0
// ============================================================================
module pci_mem_target
  import pci_pkg::*;
#(
  parameter int ADDR_BITS = 10,
  parameter int BURST_MAX = 16
) (
  input  wire logic        clk,
  input  wire logic        rst,
  input  wire logic [31:0] bar_base,
  input  wire logic        mem_enable,
  pci_mem_target_if.slave  bus
);
  localparam int                   WORD_BITS = ADDR_BITS - 2;
  localparam logic [7:0]           C_LAST    = 8'(BURST_MAX - 1);
  localparam logic [WORD_BITS-1:0] C_PTR_ONE = WORD_BITS'(1);

  pci_mem_state_t        r_state, w_state_nxt;
  logic [WORD_BITS-1:0]  r_ptr, w_ptr_nxt;
  logic [7:0]            r_cnt, w_cnt_nxt;
  logic                  r_write, w_write_nxt;
  logic                  r_unaligned, w_unaligned_nxt;
  logic                  w_hit, w_last, w_ack, w_stop;
  logic                  w_ram_re;
  logic [3:0]            w_ram_we;
  logic [WORD_BITS-1:0]  w_ram_addr;
  logic [31:0]           w_ram_rdata;
  logic                  w_unused;
`ifndef PCI_MEM_PREFETCH_EN
  logic                  r_rd_pend, w_rd_pend_nxt;
`endif

  assign w_unused = ^bar_base[ADDR_BITS-1:0];
  assign w_hit    = mem_enable && is_mem_cmd(bus.cmd) &&
                    (bus.addr[31:ADDR_BITS] == bar_base[31:ADDR_BITS]);
  // Non-linear burst order is served for exactly one phase.
  assign w_last   = (r_cnt == C_LAST) || r_unaligned;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= ST_IDLE;
      r_ptr       <= '0;
      r_cnt       <= '0;
      r_write     <= 1'b0;
      r_unaligned <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_ptr       <= w_ptr_nxt;
      r_cnt       <= w_cnt_nxt;
      r_write     <= w_write_nxt;
      r_unaligned <= w_unaligned_nxt;
    end
  end

`ifndef PCI_MEM_PREFETCH_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_rd_pend <= 1'b0;
    else      r_rd_pend <= w_rd_pend_nxt;
  end
`endif

  always_comb begin
    w_state_nxt     = r_state;
    w_ptr_nxt       = r_ptr;
    w_cnt_nxt       = r_cnt;
    w_write_nxt     = r_write;
    w_unaligned_nxt = r_unaligned;
    w_ack           = 1'b0;
    w_stop          = 1'b0;
    w_ram_re        = 1'b0;
    w_ram_we        = 4'b0000;
    w_ram_addr      = r_ptr;
`ifndef PCI_MEM_PREFETCH_EN
    w_rd_pend_nxt   = r_rd_pend;
`endif

    case (r_state)
      ST_IDLE: begin
        if (bus.addr_valid && w_hit) begin
          w_state_nxt     = ST_CLAIM;
          w_ptr_nxt       = bus.addr[ADDR_BITS-1:2];
          w_cnt_nxt       = '0;
          w_write_nxt     = is_mem_write(bus.cmd);
          w_unaligned_nxt = (bus.addr[1:0] != 2'b00);
`ifndef PCI_MEM_PREFETCH_EN
          w_rd_pend_nxt   = 1'b0;
`endif
        end
      end

      ST_CLAIM: begin
`ifdef PCI_MEM_PREFETCH_EN
        w_ram_re = !r_write;
`endif
        w_state_nxt = bus.txn_end ? ST_IDLE : ST_DATA;
      end

      ST_DATA: begin
        if (r_write) begin
          w_ack    = bus.dp_req;
          w_ram_we = bus.dp_be & {4{bus.dp_req}};
        end else begin
`ifdef PCI_MEM_PREFETCH_EN
          w_ack = bus.dp_req;
          if (bus.dp_req) begin
            w_ram_re   = 1'b1;
            w_ram_addr = r_ptr + C_PTR_ONE;
          end
`else
          // First sight of dp_req launches the RAM read; ack lands next cycle.
          if (r_rd_pend) begin
            w_ack = bus.dp_req;
          end else if (bus.dp_req) begin
            w_ram_re      = 1'b1;
            w_rd_pend_nxt = 1'b1;
          end
`endif
        end

        w_stop = w_ack && w_last;
        if (w_ack) begin
          w_ptr_nxt = r_ptr + C_PTR_ONE;
          w_cnt_nxt = r_cnt + 8'd1;
`ifndef PCI_MEM_PREFETCH_EN
          w_rd_pend_nxt = 1'b0;
`endif
        end

        if (bus.txn_end)  w_state_nxt = ST_IDLE;
        else if (w_stop)  w_state_nxt = ST_DISC;
      end

      ST_DISC: begin
        w_stop = 1'b1;
        if (bus.txn_end) w_state_nxt = ST_IDLE;
      end

      default: w_state_nxt = ST_IDLE;
    endcase
  end

  assign bus.claim    = (r_state != ST_IDLE);
  assign bus.dp_ack   = w_ack;
  assign bus.dp_stop  = w_stop;
  assign bus.dp_rdata = w_ram_rdata;

  pci_mem_ram #(
    .WORD_BITS (WORD_BITS)
  ) u_ram (
    .clk   (clk),
    .rst   (rst),
    .re    (w_ram_re),
    .we    (w_ram_we),
    .addr  (w_ram_addr),
    .wdata (bus.dp_wdata),
    .rdata (w_ram_rdata)
  );
endmodule
`default_nettype wire

// File: tb/tb_pci_mem_target.sv
`default_nettype none
// ============================================================================
// Module   : tb_pci_mem_target
// Purpose  : Randomized bench for pci_mem_target against a phase-count model
//            with a RAM shadow; directed scenarios pin the model with literals.
// Revision : 1.0
// ============================================================================
module tb_pci_mem_target;
  localparam int AB = 10;
  localparam int BM = 16;
  localparam int NW = 1 << (AB - 2);
`ifdef PCI_MEM_PREFETCH_EN
  localparam bit PF = 1'b1;
`else
  localparam bit PF = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] bar_base;
  logic        mem_enable;

  pci_mem_target_if bus ();

  pci_mem_target #(.ADDR_BITS(AB), .BURST_MAX(BM)) dut (
    .clk        (clk),
    .rst        (rst),
    .bar_base   (bar_base),
    .mem_enable (mem_enable),
    .bus        (bus)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  // Reference model: transaction bookkeeping plus shadow RAM.
  logic [31:0] mem_m [NW];
  bit          known [NW];
  int          m_phase;   // 0 idle, 1 claim cycle, 2 data phases
  int          m_acks, m_limit, m_word;
  bit          m_write, m_waited;
  bit          exp_claim, exp_ack, exp_stop, exp_rd_chk;
  logic [31:0] exp_rdata;
  bit          chk_en = 1'b0;

  logic [31:0] ack_data [$];
  int          ack_cyc  [$];
  int          first_claim, claim_cycles, stop_ack_idx;

  function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endfunction

  function automatic bit model_hit(input logic [31:0] a, input logic [3:0] c);
    bit cmd_ok;
    cmd_ok = (c == 4'h6) || (c == 4'h7) || (c == 4'hC) || (c == 4'hE) || (c == 4'hF);
    return mem_enable && cmd_ok && (a[31:AB] == bar_base[31:AB]);
  endfunction

  function automatic void predict();
    exp_claim  = (m_phase != 0);
    exp_ack    = 1'b0;
    exp_stop   = 1'b0;
    exp_rd_chk = 1'b0;
    exp_rdata  = '0;
    if (m_phase == 2) begin
      if (m_acks >= m_limit) begin
        exp_stop = 1'b1;
      end else begin
        if (m_write || PF) exp_ack = bus.dp_req;
        else               exp_ack = bus.dp_req && m_waited;
        exp_stop = exp_ack && (m_acks + 1 == m_limit);
        if (exp_ack && !m_write && known[m_word]) begin
          exp_rd_chk = 1'b1;
          exp_rdata  = mem_m[m_word];
        end
      end
    end
  endfunction

  // Applies the cycle that just ended (inputs still on the bus).
  function automatic void update();
    if (m_phase != 0 && exp_ack) begin
      if (m_write) begin
        for (int i = 0; i < 4; i++)
          if (bus.dp_be[i]) mem_m[m_word][8*i +: 8] = bus.dp_wdata[8*i +: 8];
        known[m_word] = known[m_word] | (bus.dp_be == 4'hF);
      end
      m_word   = (m_word + 1) % NW;
      m_acks   = m_acks + 1;
      m_waited = 1'b0;
    end else if (m_phase == 2 && !m_write && !PF && bus.dp_req && m_acks < m_limit) begin
      m_waited = 1'b1;
    end
    if (m_phase != 0) begin
      if (bus.txn_end)       m_phase = 0;
      else if (m_phase == 1) m_phase = 2;
    end else if (bus.addr_valid && model_hit(bus.addr, bus.cmd)) begin
      m_phase  = 1;
      m_word   = int'(bus.addr[AB-1:2]);
      m_acks   = 0;
      m_limit  = (bus.addr[1:0] != 2'b00) ? 1 : BM;
      m_write  = (bus.cmd == 4'h7) || (bus.cmd == 4'hF);
      m_waited = 1'b0;
    end
  endfunction

  function automatic void model_reset();
    m_phase = 0; m_acks = 0; m_limit = BM; m_word = 0; m_write = 0; m_waited = 0;
    for (int i = 0; i < NW; i++) known[i] = 1'b0;
  endfunction

  always @(negedge clk) begin
    if (chk_en) begin
      chk("claim",   32'(bus.claim),   32'(exp_claim));
      chk("dp_ack",  32'(bus.dp_ack),  32'(exp_ack));
      chk("dp_stop", 32'(bus.dp_stop), 32'(exp_stop));
      if (exp_rd_chk) chk("dp_rdata", bus.dp_rdata, exp_rdata);
      if (bus.dp_ack) begin
        ack_data.push_back(bus.dp_rdata);
        ack_cyc.push_back(cyc);
        if (bus.dp_stop) stop_ack_idx = ack_data.size();
      end
      if (bus.claim) begin
        claim_cycles++;
        if (first_claim < 0) first_claim = cyc;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    update();
    cyc++;
    #1;
  endtask

  task automatic drive(input bit av, input logic [31:0] a, input logic [3:0] c, input bit req,
                       input logic [31:0] wd, input logic [3:0] be, input bit te);
    bus.addr_valid = av; bus.addr = a; bus.cmd = c; bus.dp_req = req;
    bus.dp_wdata = wd; bus.dp_be = be; bus.txn_end = te;
    predict();
  endtask

  task automatic txn(input logic [31:0] a, input logic [3:0] c, input int nph,
                     input bit rnd, input bit rbe, input logic [31:0] wd, input logic [3:0] be,
                     input bit hold, output int av);
    bit seen, done, req, te, hold_prev;
    ack_data.delete(); ack_cyc.delete();
    first_claim = -1; claim_cycles = 0; stop_ack_idx = 0;
    tick();
    drive(1'b1, a, c, 1'b0, '0, '0, 1'b0);
    av = cyc; seen = 0; done = 0;
    for (int k = 0; k < 300 && !done; k++) begin
      hold_prev = bus.dp_req && !exp_ack;
      tick();
      if (m_phase != 0) seen = 1;
      if (m_phase == 0 && (seen || k >= 3)) begin
        drive(1'b0, '0, '0, 1'b0, '0, '0, 1'b0);
        done = 1;
      end else begin
        te = 0;
        if (m_phase == 0) begin
          req = 1;
        end else if (m_phase == 2 && (m_acks >= m_limit || m_acks >= nph)) begin
          req = 0; te = 1;
        end else begin
          req = hold || hold_prev || ($urandom_range(0, 3) != 0);
          if (!hold && m_phase == 2 && m_acks == nph - 1 && req && $urandom_range(0, 3) == 0) te = 1;
        end
        drive(1'b0, '0, '0, req, rnd ? 32'($urandom) : wd,
              rbe ? 4'($urandom_range(0, 15)) : be, te);
      end
    end
    chk("txn_done", 32'(done), 32'd1);
  endtask

  int av;
  logic [31:0] base;

  initial begin
    bar_base   = 32'hFEB0_0000;
    mem_enable = 1'b1;
    model_reset();
    drive(1'b0, '0, '0, 1'b0, '0, '0, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    chk("rst_claim", 32'(bus.claim),   32'd0);
    chk("rst_ack",   32'(bus.dp_ack),  32'd0);
    chk("rst_stop",  32'(bus.dp_stop), 32'd0);
    chk("rst_rdata", bus.dp_rdata,     32'd0);
    rst = 1'b1;
    chk_en = 1'b1;

    // Single write, then readback.
    txn(32'hFEB0_0010, 4'h7, 1, 0, 0, 32'hDEAD_BEEF, 4'hF, 1, av);
    chk("wr_claim_t1", 32'(first_claim), 32'(av + 1));
    chk("wr_nacks", 32'(ack_data.size()), 32'd1);
    if (ack_cyc.size() > 0) chk("wr_ack_t2", 32'(ack_cyc[0]), 32'(av + 2));
    chk("wr_no_stop", 32'(stop_ack_idx), 32'd0);
    txn(32'hFEB0_0010, 4'h6, 1, 0, 0, '0, 4'hF, 1, av);
    if (ack_data.size() > 0) chk("rd_deadbeef", ack_data[0], 32'hDEAD_BEEF);
    else chk("rd_deadbeef_n", 32'(ack_data.size()), 32'd1);

    // Byte-lane merge.
    txn(32'hFEB0_0020, 4'h7, 1, 0, 0, 32'hAAAA_AAAA, 4'hF, 1, av);
    txn(32'hFEB0_0020, 4'h7, 1, 0, 0, 32'h1122_3344, 4'h5, 1, av);
    txn(32'hFEB0_0020, 4'h6, 1, 0, 0, '0, 4'hF, 1, av);
    if (ack_data.size() > 0) chk("rd_merge", ack_data[0], 32'hAA22_AA44);
    else chk("rd_merge_n", 32'(ack_data.size()), 32'd1);

    // Fill the whole window so every later read has a known value.
    for (int b = 0; b < NW / BM; b++) begin
      base = 32'hFEB0_0000 + 32'(b * BM * 4);
      txn(base, 4'hF, BM, 1, 0, '0, 4'hF, 1, av);
      chk("fill_nacks", 32'(ack_data.size()), 32'(BM));
    end

    // Read burst wrapping at the top of the window.
    txn(32'hFEB0_03F8, 4'h7, 1, 0, 0, 32'h0000_00FE, 4'hF, 1, av);
    txn(32'hFEB0_03FC, 4'h7, 1, 0, 0, 32'h0000_00FF, 4'hF, 1, av);
    txn(32'hFEB0_0000, 4'h7, 1, 0, 0, 32'h0000_0000, 4'hF, 1, av);
    txn(32'hFEB0_03F8, 4'hC, 3, 0, 0, '0, 4'hF, 1, av);
    chk("wrap_nacks", 32'(ack_data.size()), 32'd3);
    if (ack_data.size() >= 3) begin
      chk("wrap_d0", ack_data[0], 32'h0000_00FE);
      chk("wrap_d1", ack_data[1], 32'h0000_00FF);
      chk("wrap_d2", ack_data[2], 32'h0000_0000);
      chk("wrap_gap", 32'(ack_cyc[1] - ack_cyc[0]), PF ? 32'd1 : 32'd2);
      chk("wrap_gap2", 32'(ack_cyc[2] - ack_cyc[1]), PF ? 32'd1 : 32'd2);
    end

    // 20-phase write burst is cut at BURST_MAX.
    txn(32'hFEB0_0100, 4'h7, 20, 1, 0, '0, 4'hF, 1, av);
    chk("burst_nacks", 32'(ack_data.size()), 32'(BM));
    chk("burst_stop_idx", 32'(stop_ack_idx), 32'(BM));
    chk("burst_idle", 32'(bus.claim), 32'd0);

    // Misses.
    mem_enable = 1'b0;
    txn(32'hFEB0_0010, 4'h7, 1, 0, 0, 32'h1, 4'hF, 1, av);
    chk("miss_mem_en", 32'(claim_cycles), 32'd0);
    mem_enable = 1'b1;
    txn(32'hFEB0_0010, 4'h2, 1, 0, 0, 32'h1, 4'hF, 1, av);
    chk("miss_io_rd", 32'(claim_cycles), 32'd0);
    txn(32'hFEC0_0000, 4'h6, 1, 0, 0, 32'h1, 4'hF, 1, av);
    chk("miss_addr", 32'(claim_cycles), 32'd0);

    // Randomized traffic.
    for (int t = 0; t < 40; t++) begin
      logic [31:0] a;
      logic [3:0]  c;
      logic [3:0]  cmds [8];
      cmds = '{4'h6, 4'h7, 4'hC, 4'hE, 4'hF, 4'h2, 4'h3, 4'hA};
      mem_enable = ($urandom_range(0, 9) != 0);
      a = {bar_base[31:AB], AB'($urandom)};
      if ($urandom_range(0, 7) != 0) a[1:0] = 2'b00;
      if ($urandom_range(0, 7) == 0) a[31:AB] = 22'($urandom);
      c = cmds[$urandom_range(0, 7)];
      txn(a, c, int'($urandom_range(1, 20)), 1, 1, '0, 4'hF, 0, av);
    end
    mem_enable = 1'b1;

    // Asynchronous reset in the middle of a burst.
    tick();
    drive(1'b1, 32'hFEB0_0040, 4'h7, 1'b0, '0, '0, 1'b0);
    repeat (4) begin
      tick();
      drive(1'b0, '0, '0, 1'b1, 32'($urandom), 4'hF, 1'b0);
    end
    #2;
    chk_en = 1'b0;
    rst = 1'b0;
    #1;
    chk("arst_claim", 32'(bus.claim),   32'd0);
    chk("arst_ack",   32'(bus.dp_ack),  32'd0);
    chk("arst_stop",  32'(bus.dp_stop), 32'd0);
    chk("arst_rdata", bus.dp_rdata,     32'd0);
    model_reset();
    drive(1'b0, '0, '0, 1'b0, '0, '0, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    chk_en = 1'b1;
    txn(32'hFEB0_0044, 4'h7, 2, 0, 0, 32'h5A5A_0001, 4'hF, 1, av);
    chk("post_rst_claim", 32'(first_claim), 32'(av + 1));
    chk("post_rst_nacks", 32'(ack_data.size()), 32'd2);
    if (ack_cyc.size() > 0) chk("post_rst_ack_t2", 32'(ack_cyc[0]), 32'(av + 2));

    repeat (2) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
`default_nettype wire
